// File: rtl/flash_stream_pkg.sv
// Shared types and constants for the flash-to-UART burst streaming path.
package flash_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [23:0] FLASH_BASE = 24'h400000;
  // 72 MHz system clock divided down to 115200 baud.
  localparam int unsigned DIV = 625;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with first-word-fall-through output; DEPTH must be a power of 2.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  logic [7:0]             din,
  input  logic                   pop,
  output logic [7:0]             dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

endmodule

// File: rtl/flash_burst_streamer.sv
// Burst engine: issues one flash byte read per address and streams the bytes to the UART,
// overlapping flash fetch with UART drain through a small FIFO.
module flash_burst_streamer
  import flash_stream_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = 16,
  parameter int ADDR_W     = 24
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              fl_read,
  output logic [ADDR_W-1:0] fl_addr,
  input  logic              fl_ready,
  input  logic [7:0]        fl_data,
  output logic              tx_write,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic [2:0]        dbg_state
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic              outstanding_q, outstanding_d;
  logic              fl_read_q, fl_read_d;
  logic              done_q, done_d;
  logic              tx_write_q, tx_write_d;
  logic [7:0]        tx_data_q, tx_data_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]        fifo_dout;
  logic [CW-1:0]     fifo_count;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (fifo_push),
    .din   (fl_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Handshakes: fl_read is a one-cycle request answered later by a one-cycle fl_ready;
  // tx_write is a one-cycle write issued only when tx_ready=1 and no write was issued last cycle.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    outstanding_d = outstanding_q;
    fl_read_d     = 1'b0;
    done_d        = 1'b0;
    tx_write_d    = 1'b0;
    tx_data_d     = tx_data_q;
    fifo_push     = 1'b0;
    fifo_pop      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d      = start_addr;
          remaining_d = length;
          state_d     = (length == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Reserve a slot for the read in flight so a returning byte always fits.
        if (((fifo_count + CW'(outstanding_q)) < DEPTH_C) && !fifo_full) begin
          fl_read_d     = 1'b1;
          outstanding_d = 1'b1;
          state_d       = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (fl_ready && outstanding_q) begin
          fifo_push     = 1'b1;
          outstanding_d = 1'b0;
          addr_d        = addr_q + ADDR_W'(1);
          remaining_d   = remaining_q - LEN_W'(1);
          state_d       = (remaining_q == LEN_W'(1)) ? ST_DRAIN : ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty && tx_ready && !tx_write_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_q != ST_IDLE) && !fifo_empty && tx_ready && !tx_write_q) begin
      fifo_pop   = 1'b1;
      tx_write_d = 1'b1;
      tx_data_d  = fifo_dout;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      remaining_q   <= '0;
      outstanding_q <= 1'b0;
      fl_read_q     <= 1'b0;
      done_q        <= 1'b0;
      tx_write_q    <= 1'b0;
      tx_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      outstanding_q <= outstanding_d;
      fl_read_q     <= fl_read_d;
      done_q        <= done_d;
      tx_write_q    <= tx_write_d;
      tx_data_q     <= tx_data_d;
    end
  end

  assign busy      = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_DRAIN);
  assign done      = done_q;
  assign fl_read   = fl_read_q;
  assign fl_addr   = addr_q;
  assign tx_write  = tx_write_q;
  assign tx_data   = tx_data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_flash_burst_streamer.sv
// Self-checking bench for flash_burst_streamer with flash-reader and UART behavioural models.
module tb_flash_burst_streamer;
  import flash_stream_pkg::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [23:0] start_addr = '0;
  logic [15:0] length = '0;
  logic        busy, done, fl_read, tx_write;
  logic [23:0] fl_addr;
  logic        fl_ready = 1'b0;
  logic [7:0]  fl_data = '0;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b1;
  logic [2:0]  dbg_state;

  flash_burst_streamer #(.FIFO_DEPTH(DEPTH), .LEN_W(16), .ADDR_W(24)) dut (
    .clk(clk), .rstn(rstn), .start(start), .start_addr(start_addr), .length(length),
    .busy(busy), .done(done), .fl_read(fl_read), .fl_addr(fl_addr), .fl_ready(fl_ready),
    .fl_data(fl_data), .tx_write(tx_write), .tx_data(tx_data), .tx_ready(tx_ready),
    .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  int n_vec = 0, n_err = 0;
  logic [7:0]  exp_q[$];
  logic [23:0] exp_addr_q[$];
  int n_reads, n_writes, n_done;
  int first_read_cyc, first_ready_cyc, first_write_cyc, done_cyc, start_cyc;

  // Model configuration
  int uart_cyc_cfg = 0, lat_lo = 0, lat_hi = 2;
  bit hold_low = 0, inject = 0;
  bit pend = 0, prev_read = 0;
  int lat = 0, ucnt = 0;
  logic [23:0] paddr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors plus flash and UART models, all evaluated away from the active edge.
  always @(negedge clk) begin
    if (rstn) begin
      if (fl_read) begin
        check("fl_read_spacing", 32'(prev_read), 0);
        n_reads++;
        if (first_read_cyc < 0) first_read_cyc = cyc;
        check("no_overflow", 32'((n_reads - n_writes) <= DEPTH), 1);
        if (exp_addr_q.size() == 0) check("unexpected_read", 1, 0);
        else check("fl_addr", 32'(fl_addr), 32'(exp_addr_q.pop_front()));
      end
      if (tx_write) begin
        n_writes++;
        if (first_write_cyc < 0) first_write_cyc = cyc;
        if (exp_q.size() == 0) check("unexpected_tx", 1, 0);
        else check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
        check("busy_low_at_done", 32'(busy), 0);
      end
    end
    prev_read = fl_read && rstn;

    // Flash reader: answers each read after a random latency, independent of reset.
    fl_ready = 1'b0;
    if (inject) begin
      fl_ready = 1'b1;
      fl_data  = 8'hA5;
      inject   = 0;
    end else if (pend) begin
      if (lat == 0) begin
        fl_ready = 1'b1;
        fl_data  = paddr[7:0];
        pend     = 0;
        if (first_ready_cyc < 0) first_ready_cyc = cyc;
      end else lat--;
    end
    if (fl_read && rstn) begin
      pend  = 1;
      lat   = $urandom_range(lat_hi, lat_lo);
      paddr = fl_addr;
    end

    // UART: busy for uart_cyc_cfg cycles after each write.
    if (tx_write) ucnt = uart_cyc_cfg;
    else if (ucnt > 0) ucnt--;
    tx_ready = !hold_low && (ucnt == 0) && !tx_write;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_fl_read"}, 32'(fl_read), 0);
    check({tag, "_fl_addr"}, 32'(fl_addr), 0);
    check({tag, "_tx_write"}, 32'(tx_write), 0);
    check({tag, "_tx_data"}, 32'(tx_data), 0);
  endtask

  task automatic do_burst(input logic [23:0] addr, input int len, input int uart_c,
                          input bit inj, input int hold);
    int budget;
    n_reads = 0; n_writes = 0; n_done = 0;
    first_read_cyc = -1; first_ready_cyc = -1; first_write_cyc = -1; done_cyc = -1;
    uart_cyc_cfg = uart_c;
    hold_low = (hold > 0);
    for (int i = 0; i < len; i++) begin
      exp_addr_q.push_back(24'(addr + 24'(i)));
      exp_q.push_back(8'(addr + 24'(i)));
    end
    tick(1);
    start = 1'b1; start_addr = addr; length = 16'(len); start_cyc = cyc;
    tick(1);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'(len != 0));
    budget = 300 + hold + len * (uart_c + lat_hi + 8);
    for (int k = 0; k < budget && n_done == 0; k++) begin
      if (inj && k == 3) begin
        start = 1'b1; start_addr = 24'hABCDEF; length = 16'd3;
      end else start = 1'b0;
      if (hold > 0 && k == hold) begin
        check("hold_reads", 32'(n_reads), DEPTH);
        check("hold_writes", 32'(n_writes), 0);
        hold_low = 0;
      end
      tick(1);
    end
    start = 1'b0;
    check("done_seen", 32'(n_done > 0), 1);
    tick(3);
    check("done_once", 32'(n_done), 1);
    check("busy_after_done", 32'(busy), 0);
    check("idle_state", 32'(dbg_state), 32'(ST_IDLE));
    check("reads", 32'(n_reads), 32'(len));
    check("writes", 32'(n_writes), 32'(len));
    check("exp_bytes_left", 32'(exp_q.size()), 0);
    check("exp_addrs_left", 32'(exp_addr_q.size()), 0);
    if (len > 0) begin
      check("read_latency", 32'(first_read_cyc - start_cyc), 2);
      if (hold == 0) check("write_latency", 32'(first_write_cyc - first_ready_cyc), 2);
    end else begin
      check("done_latency", 32'(done_cyc - start_cyc), 2);
    end
  endtask

  typedef struct {
    logic [23:0] addr;
    int          len;
    int          uart_c;
    int          exp_reads;
    int          exp_writes;
    logic [23:0] exp_end;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{24'h400000, 4, 20, 4, 4, 24'h400004};
    tbl[1] = '{24'h400000, 0, 20, 0, 0, 24'h400000};
    tbl[2] = '{24'hFFFFFE, 4, 3, 4, 4, 24'h000002};
    tbl[3] = '{24'h000010, 1, 0, 1, 1, 24'h000011};
    tbl[4] = '{24'h7FFFF0, 20, 1, 20, 20, 24'h800004};
    tbl[5] = '{24'h00ABCD, 17, 5, 17, 17, 24'h00ABDE};

    tick(3);
    check_reset_vals("reset");
    rstn = 1'b1;
    tick(2);

    // Table-driven bursts
    for (int v = 0; v < 6; v++) begin
      lat_lo = 0; lat_hi = 3;
      do_burst(tbl[v].addr, tbl[v].len, tbl[v].uart_c, 0, 0);
      check($sformatf("tbl%0d_reads", v), 32'(n_reads), 32'(tbl[v].exp_reads));
      check($sformatf("tbl%0d_writes", v), 32'(n_writes), 32'(tbl[v].exp_writes));
      check($sformatf("tbl%0d_end_addr", v), 32'(fl_addr), 32'(tbl[v].exp_end));
    end

    // UART stalled: reads must stop once the FIFO plus the read in flight fill it.
    do_burst(24'h100000, 40, 2, 0, 1000);

    // Start pulsed mid-burst is ignored.
    do_burst(24'h123456, 6, 4, 1, 0);

    // Reset with a read outstanding, then stale fl_ready responses.
    lat_lo = 8; lat_hi = 8;
    n_reads = 0; n_writes = 0;
    for (int i = 0; i < 8; i++) begin
      exp_addr_q.push_back(24'(24'h200000 + 24'(i)));
      exp_q.push_back(8'(i));
    end
    start = 1'b1; start_addr = 24'h200000; length = 16'd8;
    tick(1);
    start = 1'b0;
    for (int k = 0; k < 20 && n_reads == 0; k++) tick(1);
    check("reset_test_read_issued", 32'(n_reads), 1);
    tick(1);
    rstn = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
    #1;
    check_reset_vals("midburst_reset");
    tick(2);
    rstn = 1'b1;
    n_writes = 0; n_reads = 0;
    tick(12);
    inject = 1;
    tick(10);
    check("stale_no_tx", 32'(n_writes), 0);
    check("stale_no_read", 32'(n_reads), 0);
    check("stale_not_busy", 32'(busy), 0);
    lat_lo = 0; lat_hi = 2;
    do_burst(24'h300010, 2, 3, 0, 0);

    // Randomized bursts
    for (int r = 0; r < 8; r++) begin
      logic [23:0] a;
      a = ($urandom_range(3, 0) == 0) ? 24'(24'hFFFFF0 + 24'($urandom_range(15, 0))) : 24'($urandom);
      lat_lo = 0;
      lat_hi = $urandom_range(4, 0);
      do_burst(a, $urandom_range(24, 1), $urandom_range(6, 0), 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
